// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter.
// After reset it clears every architectural register to zero, one id per
// cycle. It then arbitrates between the ALU writeback (A) and the load
// writeback (B) with alternating priority. It drives a registered
// register-file write port and flags out-of-range ids in a sticky error bit.
module regfile_write_arbiter #(
    parameter int REGISTER_FILE_SIZE = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [5:0]  a_id,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [5:0]  b_id,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        rf_write_en,
    output logic [5:0]  rf_write_id,
    output logic [31:0] rf_write_data,
    output logic        busy,
    output logic        range_err
);

    // The counter is one bit wider than an id so that a 64-entry file can
    // still be compared against its size.
    localparam logic [6:0] LAST_CNT = 7'(REGISTER_FILE_SIZE - 1);
    localparam logic [6:0] SIZE_LIM = 7'(REGISTER_FILE_SIZE);
    localparam logic       GRANT_A  = 1'b0;
    localparam logic       GRANT_B  = 1'b1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  clr_cnt_q, clr_cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        rf_write_en_q, rf_write_en_d;
    logic [5:0]  rf_write_id_q, rf_write_id_d;
    logic [31:0] rf_write_data_q, rf_write_data_d;
    logic        range_err_q, range_err_d;

    logic        xfer_s;
    logic [5:0]  sel_id_s;
    logic [31:0] sel_data_s;
    logic        sel_in_range_s;

    // An id addresses a real register only when it is below the file size.
    function automatic logic id_in_range(input logic [5:0] id);
        return ({1'b0, id} < SIZE_LIM);
    endfunction

    // State and write-port registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= ST_CLEAR;
            clr_cnt_q       <= 7'd0;
            last_grant_q    <= GRANT_B;
            rf_write_en_q   <= 1'b0;
            rf_write_id_q   <= 6'd0;
            rf_write_data_q <= 32'd0;
            range_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            last_grant_q    <= last_grant_d;
            rf_write_en_q   <= rf_write_en_d;
            rf_write_id_q   <= rf_write_id_d;
            rf_write_data_q <= rf_write_data_d;
            range_err_q     <= range_err_d;
        end
    end

    // Output decode: busy while clearing, alternating-priority readiness in RUN.
    always_comb begin
        busy    = 1'b1;
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset_n) begin
            busy    = 1'b1;
            a_ready = 1'b0;
            b_ready = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    busy    = 1'b0;
                    a_ready = a_valid && (!b_valid || (last_grant_q == GRANT_B));
                    b_ready = b_valid && (!a_valid || (last_grant_q == GRANT_A));
                end
                default: begin
                    busy    = 1'b1;
                    a_ready = 1'b0;
                    b_ready = 1'b0;
                end
            endcase
        end
    end

    // Select the granted requester's id and data for the write port.
    always_comb begin
        xfer_s = a_ready || b_ready;
        if (a_ready) begin
            sel_id_s   = a_id;
            sel_data_s = a_data;
        end else begin
            sel_id_s   = b_id;
            sel_data_s = b_data;
        end
        sel_in_range_s = id_in_range(sel_id_s);
    end

    // Next-state logic for the clear sequence and the arbitrated writes.
    always_comb begin
        state_d         = state_q;
        clr_cnt_d       = clr_cnt_q;
        last_grant_d    = last_grant_q;
        rf_write_en_d   = 1'b0;
        rf_write_id_d   = rf_write_id_q;
        rf_write_data_d = rf_write_data_q;
        range_err_d     = range_err_q;
        case (state_q)
            ST_CLEAR: begin
                rf_write_en_d   = 1'b1;
                rf_write_id_d   = clr_cnt_q[5:0];
                rf_write_data_d = 32'd0;
                clr_cnt_d       = clr_cnt_q + 7'd1;
                if (clr_cnt_q == LAST_CNT) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    // Writes to id 0 and to ids outside the file are
                    // accepted and dropped; only out-of-range ids are errors.
                    rf_write_en_d   = (sel_id_s != 6'd0) && sel_in_range_s;
                    rf_write_id_d   = sel_id_s;
                    rf_write_data_d = sel_data_s;
                    range_err_d     = range_err_q || !sel_in_range_s;
                    last_grant_d    = a_ready ? GRANT_A : GRANT_B;
                end else begin
                    rf_write_en_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign rf_write_en   = rf_write_en_q;
    assign rf_write_id   = rf_write_id_q;
    assign rf_write_data = rf_write_data_q;
    assign range_err     = range_err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: clear sequences, arbitration vectors
// from a table, and reset in the middle of a clear sequence.
module tb_regfile_write_arbiter;

    localparam int SIZE = 32;

    logic        clk;
    logic        reset_n;
    logic        a_valid, b_valid;
    logic [5:0]  a_id, b_id;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        rf_write_en;
    logic [5:0]  rf_write_id;
    logic [31:0] rf_write_data;
    logic        busy, range_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en;
        logic [5:0]  id;
        logic [31:0] data;
        logic        err;
    } wr_t;

    typedef struct {
        logic        av;
        logic [5:0]  aid;
        logic [31:0] ad;
        logic        bv;
        logic [5:0]  bid;
        logic [31:0] bd;
        logic        ar;
        logic        br;
        logic        en;
        logic [5:0]  wid;
        logic [31:0] wd;
        logic        err;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[19];

    regfile_write_arbiter #(.REGISTER_FILE_SIZE(SIZE)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .a_valid       (a_valid),
        .a_id          (a_id),
        .a_data        (a_data),
        .a_ready       (a_ready),
        .b_valid       (b_valid),
        .b_id          (b_id),
        .b_data        (b_data),
        .b_ready       (b_ready),
        .rf_write_en   (rf_write_en),
        .rf_write_id   (rf_write_id),
        .rf_write_data (rf_write_data),
        .busy          (busy),
        .range_err     (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pop the oldest expected write and compare it with the write port.
    task automatic check_write(input string name);
        wr_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_en"},   {31'd0, rf_write_en}, {31'd0, e.en});
            check({name, "_id"},   {26'd0, rf_write_id}, {26'd0, e.id});
            check({name, "_data"}, rf_write_data, e.data);
            check({name, "_err"},  {31'd0, range_err}, {31'd0, e.err});
        end
    endtask

    // Run n clear cycles starting at the current negedge; requests stay valid.
    task automatic run_clear(input int n);
        wr_t w;
        a_valid = 1'b1; a_id = 6'd3; a_data = 32'hDEAD;
        b_valid = 1'b1; b_id = 6'd4; b_data = 32'hBEEF;
        for (int i = 0; i < n; i++) begin
            #1;
            check("clr_a_ready", {31'd0, a_ready}, 32'd0);
            check("clr_b_ready", {31'd0, b_ready}, 32'd0);
            check("clr_busy_pre", {31'd0, busy}, 32'd1);
            w.en = 1'b1; w.id = 6'(i); w.data = 32'd0; w.err = 1'b0;
            exp_q.push_back(w);
            @(posedge clk); #1;
            check_write("clr");
            check("clr_busy_post", {31'd0, busy}, (i == SIZE - 1) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Drive one table vector, check readiness, then the registered write.
    task automatic apply_vec(input vec_t v);
        wr_t w;
        a_valid = v.av; a_id = v.aid; a_data = v.ad;
        b_valid = v.bv; b_id = v.bid; b_data = v.bd;
        #1;
        check("vec_a_ready", {31'd0, a_ready}, {31'd0, v.ar});
        check("vec_b_ready", {31'd0, b_ready}, {31'd0, v.br});
        w.en = v.en; w.id = v.wid; w.data = v.wd; w.err = v.err;
        exp_q.push_back(w);
        @(posedge clk); #1;
        check_write("vec");
        @(negedge clk);
    endtask

    initial begin
        // Paired same-id writes, then idle.
        vecs[0]  = '{1'b1, 6'd5,  32'h11,  1'b1, 6'd5,  32'h22,  1'b1, 1'b0, 1'b1, 6'd5,  32'h11,  1'b0};
        vecs[1]  = '{1'b0, 6'd0,  32'h0,   1'b1, 6'd5,  32'h22,  1'b0, 1'b1, 1'b1, 6'd5,  32'h22,  1'b0};
        vecs[2]  = '{1'b0, 6'd0,  32'h0,   1'b0, 6'd0,  32'h0,   1'b0, 1'b0, 1'b0, 6'd5,  32'h22,  1'b0};
        // Six back-to-back cycles with both requesters valid.
        vecs[3]  = '{1'b1, 6'd1,  32'hA1,  1'b1, 6'd2,  32'hB2,  1'b1, 1'b0, 1'b1, 6'd1,  32'hA1,  1'b0};
        vecs[4]  = '{1'b1, 6'd3,  32'hA3,  1'b1, 6'd2,  32'hB2,  1'b0, 1'b1, 1'b1, 6'd2,  32'hB2,  1'b0};
        vecs[5]  = '{1'b1, 6'd3,  32'hA3,  1'b1, 6'd4,  32'hB4,  1'b1, 1'b0, 1'b1, 6'd3,  32'hA3,  1'b0};
        vecs[6]  = '{1'b1, 6'd5,  32'hA5,  1'b1, 6'd4,  32'hB4,  1'b0, 1'b1, 1'b1, 6'd4,  32'hB4,  1'b0};
        vecs[7]  = '{1'b1, 6'd5,  32'hA5,  1'b1, 6'd6,  32'hB6,  1'b1, 1'b0, 1'b1, 6'd5,  32'hA5,  1'b0};
        vecs[8]  = '{1'b1, 6'd7,  32'hA7,  1'b1, 6'd6,  32'hB6,  1'b0, 1'b1, 1'b1, 6'd6,  32'hB6,  1'b0};
        // A alone for three cycles, then idle with the write port holding.
        vecs[9]  = '{1'b1, 6'd10, 32'h100, 1'b0, 6'd0,  32'h0,   1'b1, 1'b0, 1'b1, 6'd10, 32'h100, 1'b0};
        vecs[10] = '{1'b1, 6'd10, 32'h101, 1'b0, 6'd0,  32'h0,   1'b1, 1'b0, 1'b1, 6'd10, 32'h101, 1'b0};
        vecs[11] = '{1'b1, 6'd10, 32'h102, 1'b0, 6'd0,  32'h0,   1'b1, 1'b0, 1'b1, 6'd10, 32'h102, 1'b0};
        vecs[12] = '{1'b0, 6'd0,  32'h0,   1'b0, 6'd0,  32'h0,   1'b0, 1'b0, 1'b0, 6'd10, 32'h102, 1'b0};
        // Write to id 0, then an out-of-range id, then boundary ids.
        vecs[13] = '{1'b1, 6'd0,  32'h55,  1'b0, 6'd0,  32'h0,   1'b1, 1'b0, 1'b0, 6'd0,  32'h55,  1'b0};
        vecs[14] = '{1'b0, 6'd0,  32'h0,   1'b1, 6'd40, 32'h66,  1'b0, 1'b1, 1'b0, 6'd40, 32'h66,  1'b1};
        vecs[15] = '{1'b0, 6'd0,  32'h0,   1'b0, 6'd0,  32'h0,   1'b0, 1'b0, 1'b0, 6'd40, 32'h66,  1'b1};
        vecs[16] = '{1'b1, 6'd31, 32'h77,  1'b0, 6'd0,  32'h0,   1'b1, 1'b0, 1'b1, 6'd31, 32'h77,  1'b1};
        vecs[17] = '{1'b0, 6'd0,  32'h0,   1'b1, 6'd32, 32'h88,  1'b0, 1'b1, 1'b0, 6'd32, 32'h88,  1'b1};
        vecs[18] = '{1'b1, 6'd2,  32'h99,  1'b1, 6'd3,  32'hAA,  1'b1, 1'b0, 1'b1, 6'd2,  32'h99,  1'b1};

        // Reset with requests asserted.
        reset_n = 1'b0;
        a_valid = 1'b1; a_id = 6'd7; a_data = 32'h1234;
        b_valid = 1'b1; b_id = 6'd8; b_data = 32'h5678;
        @(posedge clk); @(posedge clk); #1;
        check("rst_en",      {31'd0, rf_write_en}, 32'd0);
        check("rst_id",      {26'd0, rf_write_id}, 32'd0);
        check("rst_data",    rf_write_data, 32'd0);
        check("rst_err",     {31'd0, range_err}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd1);
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);

        // Full clear sequence after release.
        @(negedge clk);
        reset_n = 1'b1;
        run_clear(SIZE);

        // Arbitration table.
        for (int v = 0; v < 19; v++) begin
            apply_vec(vecs[v]);
        end

        // Reset in RUN clears the sticky error; then reset again mid-clear.
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst2_err", {31'd0, range_err}, 32'd0);
        check("rst2_en",  {31'd0, rf_write_en}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_clear(17);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midclr_en", {31'd0, rf_write_en}, 32'd0);
        check("midclr_id", {26'd0, rf_write_id}, 32'd0);
        check("midclr_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        run_clear(SIZE);

        // One transfer after the restarted clear.
        apply_vec(vecs[3]);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
